// File: rtl/iis_tx_buffer.sv
// Stereo sample FIFO feeding an I2S transmitter: frames are staged in an output
// register for the transmitter's read strobe; strobes on an empty stage emit silence and are counted.
module iis_tx_buffer #(
    parameter int DW    = 32,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [DW-1:0]            in_l,
    input  logic [DW-1:0]            in_r,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic [DW-1:0]            txdata [2],
    input  logic                     txdata_rd,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     underrun,
    output logic [15:0]              underrun_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = (AW+1)'(1);
    localparam logic [15:0] CNT_MAX = 16'hFFFF;

    logic [2*DW-1:0] mem_q [DEPTH];
    logic [AW:0]     wptr_q, wptr_d;
    logic [AW:0]     rptr_q, rptr_d;
    logic [AW:0]     level_q, level_d;
    logic [DW-1:0]   tx_l_q, tx_l_d;
    logic [DW-1:0]   tx_r_q, tx_r_d;
    logic            staged_q, staged_d;
    logic            ready_q, ready_d;
    logic            und_q, und_d;
    logic [15:0]     cnt_q, cnt_d;

    logic            empty_s;
    logic            full_s;
    logic            push_s;
    logic            pop_s;
    logic [2*DW-1:0] head_s;

    // Extra pointer MSB distinguishes full from empty when the low bits match.
    assign empty_s = (wptr_q == rptr_q);
    assign full_s  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign push_s  = in_valid && !full_s;
    assign pop_s   = !empty_s && (txdata_rd || !staged_q);
    assign head_s  = mem_q[rptr_q[AW-1:0]];

    // Next-state logic for pointers, staging register and underrun accounting
    always_comb begin
        wptr_d   = wptr_q;
        rptr_d   = rptr_q;
        tx_l_d   = tx_l_q;
        tx_r_d   = tx_r_q;
        staged_d = staged_q;
        if (push_s) begin
            wptr_d = wptr_q + PTR_ONE;
        end else begin
            wptr_d = wptr_q;
        end
        if (pop_s) begin
            rptr_d   = rptr_q + PTR_ONE;
            tx_l_d   = head_s[2*DW-1:DW];
            tx_r_d   = head_s[DW-1:0];
            staged_d = 1'b1;
        end else if (txdata_rd) begin
            tx_l_d   = {DW{1'b0}};
            tx_r_d   = {DW{1'b0}};
            staged_d = 1'b0;
        end else begin
            staged_d = staged_q;
        end
        und_d = txdata_rd && !staged_q;
        if (und_d && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + 16'd1;
        end else begin
            cnt_d = cnt_q;
        end
        level_d = wptr_d - rptr_d;
        ready_d = (level_d < (AW+1)'(DEPTH));
    end

    // Frame storage; contents need no reset since pointers gate every read
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_q[wptr_q[AW-1:0]] <= {in_l, in_r};
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q   <= '0;
            rptr_q   <= '0;
            level_q  <= '0;
            tx_l_q   <= '0;
            tx_r_q   <= '0;
            staged_q <= 1'b0;
            ready_q  <= 1'b1;
            und_q    <= 1'b0;
            cnt_q    <= 16'd0;
        end else begin
            wptr_q   <= wptr_d;
            rptr_q   <= rptr_d;
            level_q  <= level_d;
            tx_l_q   <= tx_l_d;
            tx_r_q   <= tx_r_d;
            staged_q <= staged_d;
            ready_q  <= ready_d;
            und_q    <= und_d;
            cnt_q    <= cnt_d;
        end
    end

    assign in_ready     = ready_q;
    assign txdata[0]    = tx_l_q;
    assign txdata[1]    = tx_r_q;
    assign level        = level_q;
    assign underrun     = und_q;
    assign underrun_cnt = cnt_q;

endmodule

// File: tb/tb_iis_tx_buffer.sv
// Bench for iis_tx_buffer: vector table, directed corner sequences and random
// traffic checked against a queue-based reference model.
module tb_iis_tx_buffer;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] in_l, in_r;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] txdata_s [2];
    logic        txdata_rd;
    logic [4:0]  level;
    logic        underrun;
    logic [15:0] underrun_cnt;

    int nchecks = 0;
    int nerrors = 0;

    iis_tx_buffer #(.DW(32), .DEPTH(16)) dut (
        .clk(clk), .rst(rst), .in_l(in_l), .in_r(in_r), .in_valid(in_valid),
        .in_ready(in_ready), .txdata(txdata_s), .txdata_rd(txdata_rd),
        .level(level), .underrun(underrun), .underrun_cnt(underrun_cnt)
    );

    always #5 clk = ~clk;

    // Reference model: FIFO contents as a queue plus the staged frame
    logic [63:0] mq [$];
    logic [31:0] m_l, m_r;
    bit          m_st, m_und, m_acc;
    int          m_cnt;

    task automatic model_edge(input logic r, input logic v, input logic [31:0] l,
                              input logic [31:0] rr, input logic rd);
        int n;
        n = mq.size();
        if (r) begin
            mq.delete();
            m_l = 32'd0; m_r = 32'd0; m_st = 1'b0; m_und = 1'b0; m_cnt = 0; m_acc = 1'b0;
        end else begin
            m_acc = v && (n < 16);
            m_und = rd && !m_st;
            if (m_und && m_cnt < 65535) m_cnt++;
            if ((rd || !m_st) && n > 0) begin
                {m_l, m_r} = mq.pop_front();
                m_st = 1'b1;
            end else if (rd) begin
                m_l = 32'd0; m_r = 32'd0; m_st = 1'b0;
            end
            if (m_acc) mq.push_back({l, rr});
        end
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        nchecks++;
        if (act !== exp) begin
            nerrors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic check_model();
        chk("m_ready", 64'(in_ready), 64'(mq.size() < 16));
        chk("m_level", 64'(level), 64'(mq.size()));
        chk("m_tx_l", 64'(txdata_s[0]), 64'(m_l));
        chk("m_tx_r", 64'(txdata_s[1]), 64'(m_r));
        chk("m_underrun", 64'(underrun), 64'(m_und));
        chk("m_cnt", 64'(underrun_cnt), 64'(m_cnt));
    endtask

    task automatic step(input logic r, input logic v, input logic [31:0] l,
                        input logic [31:0] rr, input logic rd, input bit c);
        rst = r; in_valid = v; in_l = l; in_r = rr; txdata_rd = rd;
        @(posedge clk);
        model_edge(r, v, l, rr, rd);
        #1;
        if (c) check_model();
    endtask

    typedef struct {
        logic        rst, v;
        logic [31:0] l, r;
        logic        rd;
        logic        e_rdy;
        logic [4:0]  e_lvl;
        logic [31:0] e_l, e_r;
        logic        e_und;
        logic [15:0] e_cnt;
    } vec_t;

    vec_t        tbl [15];
    logic [31:0] fl [18];
    logic [31:0] fr [18];
    logic [63:0] exp_q [$];
    logic [63:0] ef;

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_l = 32'd0; in_r = 32'd0; txdata_rd = 1'b0;
        for (int i = 0; i < 18; i++) begin
            fl[i] = 32'h1000_0000 + 32'(i);
            fr[i] = 32'h2000_0000 + 32'(i);
        end
        //               rst   v     l             r             rd    rdy   lvl   tx_l          tx_r          und   cnt
        tbl[0]  = '{1'b1, 1'b0, 32'h0,        32'h0,        1'b0, 1'b1, 5'd0, 32'h0,        32'h0,        1'b0, 16'd0};
        tbl[1]  = '{1'b0, 1'b0, 32'h0,        32'h0,        1'b0, 1'b1, 5'd0, 32'h0,        32'h0,        1'b0, 16'd0};
        tbl[2]  = '{1'b0, 1'b0, 32'h0,        32'h0,        1'b1, 1'b1, 5'd0, 32'h0,        32'h0,        1'b1, 16'd1};
        tbl[3]  = '{1'b0, 1'b0, 32'h0,        32'h0,        1'b1, 1'b1, 5'd0, 32'h0,        32'h0,        1'b1, 16'd2};
        tbl[4]  = '{1'b0, 1'b0, 32'h0,        32'h0,        1'b0, 1'b1, 5'd0, 32'h0,        32'h0,        1'b0, 16'd2};
        tbl[5]  = '{1'b0, 1'b1, 32'h11111111, 32'h22222222, 1'b0, 1'b1, 5'd1, 32'h0,        32'h0,        1'b0, 16'd2};
        tbl[6]  = '{1'b0, 1'b0, 32'h0,        32'h0,        1'b0, 1'b1, 5'd0, 32'h11111111, 32'h22222222, 1'b0, 16'd2};
        tbl[7]  = '{1'b0, 1'b0, 32'h0,        32'h0,        1'b1, 1'b1, 5'd0, 32'h0,        32'h0,        1'b0, 16'd2};
        tbl[8]  = '{1'b0, 1'b0, 32'h0,        32'h0,        1'b1, 1'b1, 5'd0, 32'h0,        32'h0,        1'b1, 16'd3};
        tbl[9]  = '{1'b0, 1'b0, 32'h0,        32'h0,        1'b0, 1'b1, 5'd0, 32'h0,        32'h0,        1'b0, 16'd3};
        tbl[10] = '{1'b0, 1'b1, 32'hAAAA0001, 32'hBBBB0002, 1'b0, 1'b1, 5'd1, 32'h0,        32'h0,        1'b0, 16'd3};
        tbl[11] = '{1'b0, 1'b0, 32'h0,        32'h0,        1'b0, 1'b1, 5'd0, 32'hAAAA0001, 32'hBBBB0002, 1'b0, 16'd3};
        tbl[12] = '{1'b0, 1'b1, 32'hCCCC0003, 32'hDDDD0004, 1'b1, 1'b1, 5'd1, 32'h0,        32'h0,        1'b0, 16'd3};
        tbl[13] = '{1'b0, 1'b0, 32'h0,        32'h0,        1'b0, 1'b1, 5'd0, 32'hCCCC0003, 32'hDDDD0004, 1'b0, 16'd3};
        tbl[14] = '{1'b1, 1'b0, 32'h0,        32'h0,        1'b0, 1'b1, 5'd0, 32'h0,        32'h0,        1'b0, 16'd0};

        for (int i = 0; i < 15; i++) begin
            step(tbl[i].rst, tbl[i].v, tbl[i].l, tbl[i].r, tbl[i].rd, 1'b1);
            chk("tbl_ready", 64'(in_ready), 64'(tbl[i].e_rdy));
            chk("tbl_level", 64'(level), 64'(tbl[i].e_lvl));
            chk("tbl_tx_l", 64'(txdata_s[0]), 64'(tbl[i].e_l));
            chk("tbl_tx_r", 64'(txdata_s[1]), 64'(tbl[i].e_r));
            chk("tbl_underrun", 64'(underrun), 64'(tbl[i].e_und));
            chk("tbl_cnt", 64'(underrun_cnt), 64'(tbl[i].e_cnt));
        end

        // Fill to DEPTH+1 frames, hold an 18th, then drain in order
        step(1'b1, 1'b0, 32'd0, 32'd0, 1'b0, 1'b1);
        for (int i = 0; i < 17; i++) step(1'b0, 1'b1, fl[i], fr[i], 1'b0, 1'b1);
        chk("full_level", 64'(level), 64'd16);
        chk("full_ready", 64'(in_ready), 64'd0);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, fl[17], fr[17], 1'b0, 1'b1);
        chk("hold_level", 64'(level), 64'd16);
        for (int i = 0; i < 17; i++) begin
            chk("drain_l", 64'(txdata_s[0]), 64'(fl[i]));
            chk("drain_r", 64'(txdata_s[1]), 64'(fr[i]));
            step(1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 1'b1);
            if (i == 0) chk("drain_ready", 64'(in_ready), 64'd1);
        end
        chk("drain_empty_l", 64'(txdata_s[0]), 64'd0);
        chk("drain_cnt", 64'(underrun_cnt), 64'd0);

        // Push and strobe together at level 5
        step(1'b1, 1'b0, 32'd0, 32'd0, 1'b0, 1'b1);
        for (int i = 0; i < 6; i++) step(1'b0, 1'b1, fl[i], fr[i], 1'b0, 1'b1);
        chk("lvl5_before", 64'(level), 64'd5);
        step(1'b0, 1'b1, fl[6], fr[6], 1'b1, 1'b1);
        chk("lvl5_after", 64'(level), 64'd5);
        chk("lvl5_tx_l", 64'(txdata_s[0]), 64'(fl[1]));

        // Reset with level 8 and three counted underruns
        step(1'b1, 1'b0, 32'd0, 32'd0, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 1'b1);
        for (int i = 0; i < 9; i++) step(1'b0, 1'b1, fl[i], fr[i], 1'b0, 1'b1);
        chk("pre_rst_level", 64'(level), 64'd8);
        chk("pre_rst_cnt", 64'(underrun_cnt), 64'd3);
        step(1'b1, 1'b0, 32'd0, 32'd0, 1'b0, 1'b1);
        chk("rst_level", 64'(level), 64'd0);
        chk("rst_cnt", 64'(underrun_cnt), 64'd0);
        chk("rst_ready", 64'(in_ready), 64'd1);
        chk("rst_tx", {txdata_s[0], txdata_s[1]}, 64'd0);

        // Random traffic against the model
        for (int i = 0; i < 2000; i++)
            step(1'b0, 1'($urandom_range(0, 1)), $urandom, $urandom, 1'($urandom_range(0, 2) == 0), 1'b1);

        // Transmitter-paced strobes with ample supply: order preserved, no underrun
        step(1'b1, 1'b0, 32'd0, 32'd0, 1'b0, 1'b1);
        exp_q.delete();
        for (int c = 0; c < 3000; c++) begin
            logic rd;
            logic v;
            logic [31:0] dl, dr;
            rd = (c >= 8) && ((c % 32) == 31);
            v  = (c < 4) || ($urandom_range(0, 1) == 1);
            dl = $urandom; dr = $urandom;
            if (rd) begin
                ef = (exp_q.size() > 0) ? exp_q.pop_front() : 64'd0;
                chk("paced_frame", {txdata_s[0], txdata_s[1]}, ef);
            end
            step(1'b0, v, dl, dr, rd, 1'b1);
            if (m_acc) exp_q.push_back({dl, dr});
            if (rd) chk("paced_no_underrun", 64'(underrun), 64'd0);
        end

        // Saturate the underrun counter
        step(1'b1, 1'b0, 32'd0, 32'd0, 1'b0, 1'b1);
        for (int i = 0; i < 70000; i++) step(1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
        chk("sat_cnt", 64'(underrun_cnt), 64'hFFFF);
        step(1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 1'b1);
        chk("sat_cnt_hold", 64'(underrun_cnt), 64'hFFFF);
        chk("sat_underrun", 64'(underrun), 64'd1);

        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
        $finish;
    end

endmodule

// File: doc/iis_tx_buffer.md
# iis_tx_buffer

Stereo sample FIFO that sits directly upstream of the I2S transmitter and feeds it. A producer such as a DSP chain or DMA pushes left/right sample pairs over a valid/ready port. The block keeps the next frame staged in an output register so the transmitter can latch it on its one-cycle `txdata_rd` strobe. Underruns produce silence and are counted.

## Interface
Parameters:
- `DW`, 32, sample width in bits (signed two's complement).
- `DEPTH`, 16, FIFO depth in frames. Must be a power of 2 and at least 2.

Ports:
- `clk`  in  1  system clock (same clock as the transmitter and clock generator).
- `rst`  in  1  reset. Synchronous, active-high.
- `in_l`  in  DW  left sample, signed.
- `in_r`  in  DW  right sample, signed.
- `in_valid`  in  1  producer offers a frame.
- `in_ready`  out  1  FIFO can accept a frame.
- `txdata`  out  DW x [2]  staged frame. Index 0 is left, index 1 is right. Unpacked array, matching the transmitter's input.
- `txdata_rd`  in  1  transmitter latched `txdata` this cycle. One-cycle strobe per frame.
- `level`  out  $clog2(DEPTH)+1  frames held in the FIFO, excluding the staged frame.
- `underrun`  out  1  one-cycle pulse when the transmitter consumed an invalid (silent) frame.
- `underrun_cnt`  out  16  underrun count, saturating.

## Operation
- Storage: a DEPTH-entry RAM of {l, r} with write/read pointers of $clog2(DEPTH)+1 bits, so wrap-around is unambiguous. Full when the MSBs differ and the low bits are equal. Empty when the pointers are equal.
- Staging register `txdata` plus an internal flag `staged`.
- Push: when `in_valid && in_ready`, write the frame at `wptr` and increment it. When `in_ready`=0, `in_valid` is ignored and data is neither lost nor overwritten.
- `in_ready` = `level` < DEPTH, derived from registered pointers, so it reflects pushes and pops up to the previous edge.
- Stage-fill: when `staged`=0, `txdata_rd`=0 and the FIFO is non-empty, load the head into `txdata`, set `staged`=1 and increment `rptr`.
- Consume, when `txdata_rd`=1:
  - If the FIFO is non-empty, load the head into `txdata`, set `staged`=1 and increment `rptr`.
  - If the FIFO is empty, set `txdata` to {0,0} and `staged`=0.
  - If `staged` was 0 at the strobe, the transmitter took a silent frame: pulse `underrun` and increment `underrun_cnt`, saturating at 16'hFFFF.
- Simultaneous push and pop: both take effect and `level` is unchanged. There is no bypass. A push into an empty FIFO is not visible to a pop or stage-fill in the same cycle.
- `txdata_rd` while full: the pop proceeds and `in_ready` rises on the next cycle.
- Reset (any time, including mid-frame): pointers, `level`, `staged`, `underrun` and `underrun_cnt` return to 0, and `txdata` returns to {0,0}. Frames held in the FIFO are discarded.

## Timing
- Reset values: `in_ready`=1, `txdata`={0,0}, `level`=0, `underrun`=0, `underrun_cnt`=0. `in_ready` is 1 in the cycle after `rst` deasserts.
- First frame into an empty buffer: accepted at edge N, `level`=1 after N, staged into `txdata` at edge N+1, `level`=0 after N+1.
- Pop: the transmitter samples the old `txdata` in the strobe cycle. The new frame (or zeros) appears on `txdata` after that edge.
- `underrun` is asserted in the cycle after the offending strobe. `underrun_cnt` updates at the same edge.
- Total capacity is DEPTH+1 frames (the FIFO plus the staged frame).
- All outputs are registered. There is no combinational path from `txdata_rd` or `in_valid` to any output.

## Test plan
- Reset then idle: check `in_ready`=1, `level`=0, `txdata`={0,0}. Pulse `txdata_rd` twice: `underrun` pulses twice and `underrun_cnt`=2.
- Push (L,R) = (32'h11111111, 32'h22222222) at edge N: `txdata` equals that frame after N+1 and `level`=0. Strobe: `txdata` becomes {0,0} and there is no underrun. Strobe again: underrun, with `underrun_cnt` incremented by 1.
- Push 17 frames (DEPTH=16) with no reads: 1 frame staged and `level`=16. `in_ready` drops after the 17th accept. An 18th frame held on `in_valid` is not accepted. Drain 17 strobes and check the frames come out in push order with no loss, and `in_ready` returns after the first strobe.
- Frames of `$random` data pushed while an `IisClkGen(64,8)` and `IisTransmitter` pair strobes `txdata_rd` every 512 clocks: `IisReceiver` output matches the pushed sequence and `underrun` never fires.
- Push and strobe in the same cycle at `level`=5: `level` stays 5 and `txdata` advances one frame. Repeat with `level`=0 and `staged`=1: the strobe yields {0,0} and the pushed frame is staged one cycle later.
- Assert `rst` for one cycle with `level`=8 and `underrun_cnt`=3: all outputs return to their reset values on the next cycle. Force 70000 underruns: `underrun_cnt` saturates at 16'hFFFF.
